// File: rtl/xeng_bl_sched_if.sv
// Control/status bundle between the X-engine baseline sequencer and its surroundings.
// master drives the requests and backpressure; slave is the sequencer.
interface xeng_bl_sched_if #(
  parameter int ACC_BITS = 16
);
  logic                arm;
  logic [ACC_BITS-1:0] acc_len;
  logic                spec_rdy;
  logic                hold;
  logic                bl_sync;
  logic                bl_en;
  logic                spec_ack;
  logic                acc_first;
  logic                acc_last;
  logic                dump;
  logic [ACC_BITS-1:0] win_cnt;
  logic                busy;
  logic                rearm_err;

  modport master (
    output arm, acc_len, spec_rdy, hold,
    input  bl_sync, bl_en, spec_ack, acc_first, acc_last, dump, win_cnt, busy, rearm_err
  );

  modport slave (
    input  arm, acc_len, spec_rdy, hold,
    output bl_sync, bl_en, spec_ack, acc_first, acc_last, dump, win_cnt, busy, rearm_err
  );
endinterface

// File: rtl/xeng_bl_sched.sv
// Sequences one full baseline pass of the order generator per buffered spectrum and
// frames accumulation windows of acc_len spectra. Every output is a flop.
module xeng_bl_sched #(
  parameter int N_ANTS   = 16,
  parameter int ACC_BITS = 16
) (
  input logic            clk,
  input logic            rst,
  xeng_bl_sched_if.slave bus
);
  localparam int PASS_LEN = N_ANTS * (N_ANTS / 2 + 1);
  localparam int PW       = $clog2(PASS_LEN);

  typedef logic [PW-1:0]       pass_t;
  typedef logic [ACC_BITS-1:0] acc_t;

  localparam pass_t PASS_LAST = pass_t'(PASS_LEN - 1);
  localparam pass_t PASS_ONE  = pass_t'(1);
  localparam acc_t  ONE       = acc_t'(1);

  typedef enum logic [1:0] {IDLE, SYNC, WAIT, RUN} state_t;

  state_t state, state_nx;
  pass_t  pass_cnt, pass_nx;
  acc_t   spec_cnt, spec_nx, win_q, win_nx, len_q, len_nx;
  logic   en_nx, err_nx, last_beat;
  logic   sync_d, ack_d, first_d, last_d, dump_d, busy_d;

  logic   bl_sync_q, bl_en_q, spec_ack_q, acc_first_q, acc_last_q, dump_q, busy_q, err_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state and next counter values. en_nx is bl_en for the coming cycle, so the
  // registered flags below are all derived from next-cycle quantities.
  always_comb begin
    state_nx  = state;
    pass_nx   = pass_cnt;
    spec_nx   = spec_cnt;
    win_nx    = win_q;
    len_nx    = len_q;
    en_nx     = 1'b0;
    err_nx    = err_q;
    last_beat = bl_en_q && (pass_cnt == PASS_LAST);
    unique case (state)
      IDLE: if (bus.arm) state_nx = SYNC;
      SYNC: state_nx = WAIT;
      WAIT: begin
        if (bus.arm) state_nx = SYNC;
        else if (bus.spec_rdy && !bus.hold) begin
          state_nx = RUN;
          en_nx    = 1'b1;
          if (spec_cnt == '0) len_nx = (bus.acc_len == '0) ? ONE : bus.acc_len;
        end
      end
      RUN: begin
        if (bus.arm) state_nx = SYNC;
        else if (last_beat) begin
          state_nx = WAIT;
          pass_nx  = '0;
          if (spec_cnt == len_q - ONE) begin
            spec_nx = '0;
            win_nx  = win_q + ONE;
          end else begin
            spec_nx = spec_cnt + ONE;
          end
        end else begin
          if (bl_en_q) pass_nx = pass_cnt + PASS_ONE;
          en_nx = !bus.hold;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (bus.arm && (state == RUN || (state == WAIT && spec_cnt != '0))) err_nx = 1'b1;
    // Any (re)sync drops the partial pass/window, so win_cnt reads 0 alongside bl_sync.
    if (state_nx == SYNC || state == SYNC) begin
      pass_nx = '0;
      spec_nx = '0;
      win_nx  = '0;
    end
  end

  always_comb begin
    sync_d  = (state_nx == SYNC);
    busy_d  = (state_nx != IDLE);
    first_d = en_nx && (spec_nx == '0);
    last_d  = en_nx && (spec_nx == len_nx - ONE);
    ack_d   = en_nx && (pass_nx == PASS_LAST);
    dump_d  = ack_d && (spec_nx == len_nx - ONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pass_cnt <= '0;
      spec_cnt <= '0;
      win_q    <= '0;
      len_q    <= '0;
    end else begin
      pass_cnt <= pass_nx;
      spec_cnt <= spec_nx;
      win_q    <= win_nx;
      len_q    <= len_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bl_sync_q   <= 1'b0;
      bl_en_q     <= 1'b0;
      spec_ack_q  <= 1'b0;
      acc_first_q <= 1'b0;
      acc_last_q  <= 1'b0;
      dump_q      <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      bl_sync_q   <= sync_d;
      bl_en_q     <= en_nx;
      spec_ack_q  <= ack_d;
      acc_first_q <= first_d;
      acc_last_q  <= last_d;
      dump_q      <= dump_d;
      busy_q      <= busy_d;
      err_q       <= err_nx;
    end
  end

  assign bus.bl_sync   = bl_sync_q;
  assign bus.bl_en     = bl_en_q;
  assign bus.spec_ack  = spec_ack_q;
  assign bus.acc_first = acc_first_q;
  assign bus.acc_last  = acc_last_q;
  assign bus.dump      = dump_q;
  assign bus.win_cnt   = win_q;
  assign bus.busy      = busy_q;
  assign bus.rearm_err = err_q;
endmodule

// File: tb/tb_xeng_bl_sched.sv
// Directed bench for xeng_bl_sched at N_ANTS=4 (12-cycle passes): a per-cycle vector
// table for the basic flow plus hand sequences for hold, spec_rdy gaps, re-arm and reset.
module tb_xeng_bl_sched;
  logic clk;
  logic rst;

  xeng_bl_sched_if #(.ACC_BITS(16)) bus ();

  xeng_bl_sched #(.N_ANTS(4), .ACC_BITS(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        arm;
    logic [15:0] len;
    logic        rdy;
    logic        hold;
    logic [7:0]  flags;  // {sync,en,ack,first,last,dump,busy,err}
    logic [15:0] win;
  } vec_t;

  vec_t tbl [32];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [7:0] fl(bit s, bit e, bit a, bit f, bit l, bit d, bit b, bit r);
    return {s, e, a, f, l, d, b, r};
  endfunction

  function automatic logic [7:0] outs();
    return {bus.bl_sync, bus.bl_en, bus.spec_ack, bus.acc_first, bus.acc_last,
            bus.dump, bus.busy, bus.rearm_err};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.arm = 1'b0; bus.acc_len = 16'd1; bus.spec_rdy = 1'b0; bus.hold = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic arm_pulse();
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
  endtask

  // Runs one acc_len=3 window (36 bl_en cycles) from the current point and checks framing.
  task automatic run_window3(input string tag);
    int n, bad_f, bad_l, dumps, dump_at;
    n = 0; bad_f = 0; bad_l = 0; dumps = 0; dump_at = 0;
    for (int c = 0; c < 200 && n < 36; c++) begin
      if (bus.bl_en) begin
        n++;
        if (bus.acc_first != (n <= 12)) bad_f++;
        if (bus.acc_last != (n >= 25)) bad_l++;
        if (bus.dump) begin dumps++; dump_at = n; end
      end else if (bus.acc_first || bus.acc_last || bus.dump) begin
        bad_f++;
      end
      tick();
    end
    check({tag, "_en_cnt"}, n, 36);
    check({tag, "_first"}, bad_f, 0);
    check({tag, "_last"}, bad_l, 0);
    check({tag, "_dumps"}, dumps, 1);
    check({tag, "_dump_at"}, dump_at, 36);
    check({tag, "_win"}, bus.win_cnt, 1);
  endtask

  initial begin
    int n, t0, gaps, ack_ofs, hc, acks, dumps, bad;
    bit got;

    for (int k = 0; k < 32; k++) begin
      tbl[k].arm   = (k == 0 || k == 28);
      tbl[k].len   = (k < 15) ? 16'd1 : 16'd0;
      tbl[k].rdy   = 1'b1;
      tbl[k].hold  = 1'b0;
      tbl[k].flags = fl(0, 0, 0, 0, 0, 0, 1, 0);
      tbl[k].win   = (k >= 15 && k <= 27) ? 16'd1 : 16'd0;
    end
    tbl[0].flags  = 8'h00;
    tbl[1].flags  = fl(1, 0, 0, 0, 0, 0, 1, 0);
    for (int k = 3; k <= 13; k++) tbl[k].flags = fl(0, 1, 0, 1, 1, 0, 1, 0);
    tbl[14].flags = fl(0, 1, 1, 1, 1, 1, 1, 0);
    for (int k = 16; k <= 26; k++) tbl[k].flags = fl(0, 1, 0, 1, 1, 0, 1, 0);
    tbl[27].flags = fl(0, 1, 1, 1, 1, 1, 1, 0);
    tbl[28].win   = 16'd2;
    tbl[29].flags = fl(1, 0, 0, 0, 0, 0, 1, 0);
    tbl[31].flags = fl(0, 1, 0, 1, 1, 0, 1, 0);

    // Basic flow: acc_len=1 then 0, continuous spec_rdy, re-arm from WAIT at cycle 28.
    do_reset();
    check("reset", {16'd0, outs(), bus.win_cnt[7:0]}, 32'd0);
    for (int k = 0; k < 32; k++) begin
      check($sformatf("vec%0d", k), {outs(), bus.win_cnt}, {tbl[k].flags, tbl[k].win});
      bus.arm = tbl[k].arm; bus.acc_len = tbl[k].len;
      bus.spec_rdy = tbl[k].rdy; bus.hold = tbl[k].hold;
      tick();
    end

    // acc_len=3 window framing.
    do_reset();
    bus.acc_len = 16'd3; bus.spec_rdy = 1'b1;
    arm_pulse();
    run_window3("l3");

    // Hold for 5 cycles after the 5th bl_en.
    do_reset();
    bus.spec_rdy = 1'b1;
    arm_pulse();
    n = 0; t0 = -1; gaps = 0; ack_ofs = -1; hc = -1; got = 0;
    for (int c = 0; c < 100 && !got; c++) begin
      if (bus.bl_en) begin
        n++;
        if (t0 < 0) t0 = c;
      end else if (t0 >= 0) begin
        gaps++;
      end
      if (bus.spec_ack) begin ack_ofs = c - t0; got = 1; end
      if (hc >= 0 && hc < 5) begin hc++; if (hc == 5) bus.hold = 1'b0; end
      if (n == 5 && hc < 0) begin bus.hold = 1'b1; hc = 0; end
      if (!got) tick();
    end
    check("hold_got_ack", got, 1);
    check("hold_en_cnt", n, 12);
    check("hold_gap", gaps, 5);
    check("hold_ack_ofs", ack_ofs, 16);

    // spec_rdy low after spec_ack parks the sequencer in WAIT.
    do_reset();
    bus.spec_rdy = 1'b1;
    arm_pulse();
    got = 0;
    for (int c = 0; c < 50 && !got; c++) begin
      if (bus.spec_ack) got = 1;
      else tick();
    end
    check("rdy_got_ack", got, 1);
    bus.spec_rdy = 1'b0;
    bad = 0;
    repeat (4) begin
      tick();
      if (bus.bl_en || !bus.busy) bad++;
    end
    check("rdy_wait", bad, 0);
    bus.spec_rdy = 1'b1;
    tick();
    check("rdy_resume", bus.bl_en, 1);

    // Re-arm at the 6th bl_en of pass 2 of a 3-spectrum window.
    do_reset();
    bus.acc_len = 16'd3; bus.spec_rdy = 1'b1;
    arm_pulse();
    n = 0; acks = 0; dumps = 0;
    for (int c = 0; c < 100 && n < 18; c++) begin
      if (bus.bl_en) n++;
      if (bus.spec_ack) acks++;
      if (bus.dump) dumps++;
      if (n < 18) tick();
    end
    check("abort_reach", n, 18);
    check("abort_acks", acks, 1);
    check("abort_dumps", dumps, 0);
    arm_pulse();
    check("abort_sync", {outs(), bus.win_cnt}, {fl(1, 0, 0, 0, 0, 0, 1, 1), 16'd0});
    run_window3("rewin");
    check("err_sticky", bus.rearm_err, 1);

    // Reset in the middle of a pass.
    got = 0;
    for (int c = 0; c < 50 && !got; c++) begin
      if (bus.bl_en) got = 1;
      else tick();
    end
    check("rst_in_run", got, 1);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_clear", {outs(), bus.win_cnt}, 24'd0);
    bad = 0;
    repeat (10) begin
      tick();
      if (bus.bl_en || bus.busy || bus.bl_sync) bad++;
    end
    check("rst_idle", bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/xeng_bl_sched.md
Name: xeng_bl_sched

Overview:
- Sequencing controller for the X-engine baseline order generator and its accumulators.
- Waits for a complete antenna spectrum from the input buffer, then issues the generator's sync pulse and enable.
- Counts exactly one full baseline pass per spectrum and one accumulation window per ACC_LEN spectra.
- Emits first/last/dump flags for the accumulator and dump logic.

Parameters:
N_ANTS, 16, antenna count; must match the order generator; power of two, >=4.
ACC_BITS, 16, width of the accumulation-length input and the window counter.
PASS_LEN (localparam), N_ANTS*(N_ANTS/2+1), generator enable cycles per full pass (144 at default); one full pass returns the generator to its post-sync state.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
arm  in  1  one-cycle start/re-sync request
acc_len  in  ACC_BITS  spectra per accumulation; 0 is treated as 1
spec_rdy  in  1  level; at least one unconsumed spectrum is buffered
hold  in  1  downstream backpressure; stalls the pass while high
bl_sync  out  1  one-cycle sync to the order generator
bl_en  out  1  order-generator enable
spec_ack  out  1  pulse; the current spectrum is fully consumed
acc_first  out  1  qualifies bl_en cycles of the first spectrum in a window
acc_last  out  1  qualifies bl_en cycles of the last spectrum in a window
dump  out  1  pulse; the accumulation window is complete
win_cnt  out  ACC_BITS  completed windows since the last sync; wraps
busy  out  1  high in any state other than IDLE
rearm_err  out  1  sticky; arm was received while a pass was active

Behaviour:
- Reset values: all outputs 0; state IDLE; internal counters 0.
- All outputs are registered.
- States: IDLE, SYNC, WAIT, RUN.
- IDLE: on arm -> SYNC. Otherwise stay.
- SYNC (1 cycle):
  - bl_sync=1.
  - Clear pass_cnt, spec_cnt and win_cnt.
  - Go to WAIT.
- WAIT:
  - bl_en=0.
  - If spec_rdy=1 and hold=0 -> RUN.
  - If spec_cnt==0 on that transition, latch the effective acc_len as len_q.
- RUN:
  - bl_en = ~hold.
  - pass_cnt increments only on cycles where bl_en=1.
  - While hold=1: bl_en=0 and all counters frozen.
- acc_first = (spec_cnt==0) & bl_en.
- acc_last = (spec_cnt==len_q-1) & bl_en.
- When len_q=1, acc_first and acc_last are both high.
- Final bl_en of a pass (pass_cnt==PASS_LEN-1): in the same cycle, spec_ack=1 and pass_cnt wraps to 0. Then:
  - If spec_cnt==len_q-1: dump=1 in that same cycle, spec_cnt<=0, win_cnt increments (wrapping at 2^ACC_BITS).
  - Otherwise spec_cnt increments.
  - Next state is WAIT.
- Minimum gap between passes is 1 cycle:
  - The source must update spec_rdy by the cycle after spec_ack.
  - spec_rdy is not sampled in the spec_ack cycle.
- Timing contract with the order generator:
  - The baseline consumed by a bl_en cycle appears on the generator outputs one cycle later.
  - acc_first and acc_last are co-timed with bl_en; downstream delays them by 1 to align with the baselines.
- acc_len is sampled only at window start. Changes mid-window take effect at the next window.
- arm outside IDLE:
  - Goes to SYNC next cycle and aborts the partial pass/window.
  - No spec_ack or dump is issued for the aborted work.
  - rearm_err is set if the state was RUN, or WAIT with spec_cnt!=0.
  - rearm_err is cleared only by rst.
- rst mid-pass: immediate return to IDLE with all outputs 0. The generator is not re-synced until the next arm.
- spec_rdy dropping during RUN is ignored; a started pass always completes.
- hold does not block SYNC; bl_sync is never suppressed.

Test Plan:
- (N_ANTS=4, PASS_LEN=12, acc_len=1, spec_rdy=1, hold=0) arm at cycle 0:
  - bl_sync at cycle 1.
  - bl_en cycles 3-14.
  - spec_ack, dump and acc_last at cycle 14; acc_first high throughout.
  - win_cnt=1 at cycle 15.
  - Next pass bl_en starts at cycle 16.
- acc_len=3, continuous spec_rdy:
  - acc_first only during the 1st pass; acc_last only during the 3rd pass.
  - dump only at the 36th bl_en; win_cnt=1.
  - acc_len=0 behaves identically to 1.
- hold high for 5 cycles mid-pass:
  - bl_en low for exactly those cycles.
  - spec_ack still after exactly 12 bl_en cycles, delayed by 5.
- spec_rdy low after a spec_ack: FSM stays in WAIT with bl_en=0; resumes the cycle after spec_rdy rises.
- arm at the 6th bl_en of pass 2 of 3:
  - No spec_ack or dump.
  - bl_sync next cycle; rearm_err=1; win_cnt=0.
  - The following window counts from spectrum 0.
- rst asserted mid-RUN:
  - All outputs 0 next cycle; state IDLE.
  - No bl_en until a new arm.
